// File: rtl/ring_osc_trim_seq.sv
// ring_osc_trim_seq
//   Trim sequencer for an NSTAGES-stage ring oscillator with two trim bits per stage.
//   Turns a binary frequency code into the oscillator's thermometer-style trim word. The
//   primary bits [NSTAGES-1:0] fill first, then the secondary bits [2*NSTAGES-1:NSTAGES].
//   Code changes are slewed at one LSB per STEP_DIV cycles, so the oscillator never jumps
//   frequency. The block also sequences the oscillator reset on start and stop.
//
// Ports
//   clock       system clock
//   resetb      asynchronous active-low reset
//   enable      run request; 0 stops the oscillator (trim state is kept for a restart)
//   code_in     target trim code; values above 2*NSTAGES are clamped
//   code_valid  code_in offered; accepted when code_valid && code_ready && enable
//   code_frac   (RING_OSC_TRIM_DITHER_EN only) half-LSB request, sampled with code_in
//   code_ready  high in RUN while cur_code has reached the target
//   trim_out    registered trim word, map(cur_code) one cycle after cur_code changes
//   osc_reset   registered oscillator reset, active high
//   cur_code    code currently applied to trim_out
//   busy        high while starting or slewing
//
// Build option
//   RING_OSC_TRIM_DITHER_EN: adds code_frac. In RUN with frac set, trim_out alternates
//   between map(cur_code) and map(cur_code+1) every STEP_DIV cycles.

module ring_osc_trim_seq #(
    parameter int unsigned NSTAGES   = 13,
    parameter int unsigned CODE_W    = 5,
    parameter int unsigned STEP_DIV  = 4,
    parameter int unsigned START_CYC = 8
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic                   enable,
    input  logic [CODE_W-1:0]      code_in,
    input  logic                   code_valid,
`ifdef RING_OSC_TRIM_DITHER_EN
    input  logic                   code_frac,
`endif
    output logic                   code_ready,
    output logic [2*NSTAGES-1:0]   trim_out,
    output logic                   osc_reset,
    output logic [CODE_W-1:0]      cur_code,
    output logic                   busy
);

    localparam int unsigned TrimW  = 2 * NSTAGES;
    localparam int unsigned StepW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned StartW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam logic [CODE_W-1:0] MaxCode = CODE_W'(TrimW);

    typedef enum logic [1:0] {StIdle, StStart, StRun, StSlew} state_e;

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   cur_code_q, cur_code_d;
    logic [CODE_W-1:0]   target_q, target_d;
    logic [TrimW-1:0]    trim_q, trim_d;
    logic                osc_reset_q, osc_reset_d;
    logic [StartW-1:0]   start_cnt_q, start_cnt_d;
    logic [StepW-1:0]    step_cnt_q, step_cnt_d;

    logic                handshake;
    logic                step_wrap;
    logic                start_done;
    logic [CODE_W-1:0]   step_code;
    logic [CODE_W-1:0]   code_clamped;
    logic                dith_inc;

    // Bit i is set when i < c: primary bits fill first, secondary bits follow.
    function automatic logic [TrimW-1:0] trim_map(input logic [CODE_W-1:0] c);
        logic [TrimW-1:0] m;
        for (int unsigned i = 0; i < TrimW; i++) begin
            m[i] = (i < 32'(c));
        end
        return m;
    endfunction

    // A handshake while enable is falling is dropped.
    assign handshake    = code_valid && code_ready && enable;
    assign step_wrap    = (step_cnt_q == StepW'(STEP_DIV - 1));
    assign start_done   = (start_cnt_q == StartW'(START_CYC - 1));
    assign code_clamped = (code_in > MaxCode) ? MaxCode : code_in;

    // One LSB toward the target, saturating at both ends of the code range.
    always_comb begin
        step_code = cur_code_q;
        if (target_q > cur_code_q && cur_code_q != MaxCode) begin
            step_code = cur_code_q + CODE_W'(1);
        end else if (target_q < cur_code_q && cur_code_q != '0) begin
            step_code = cur_code_q - CODE_W'(1);
        end
    end

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StStart;
                StStart: if (start_done) state_d = StRun;
                StRun:   if (target_q != cur_code_q) state_d = StSlew;
                StSlew: begin
                    // Back to RUN on the same edge that cur_code lands on the target.
                    if (cur_code_q == target_q) begin
                        state_d = StRun;
                    end else if (step_wrap && step_code == target_q) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        code_ready  = (state_q == StRun) && (cur_code_q == target_q);
        busy        = (state_q == StStart) || (state_q == StSlew);
        // osc_reset is registered, so it follows the state being entered.
        osc_reset_d = (state_d == StIdle) || (state_d == StStart);
    end

    // ---------------------------------------------------------------- datapath next state
    always_comb begin
        cur_code_d = cur_code_q;
        if (state_q == StSlew && step_wrap && enable) begin
            cur_code_d = step_code;
        end

        target_d = target_q;
        if (handshake) begin
            target_d = code_clamped;
        end

        start_cnt_d = '0;
        if (state_q == StStart && state_d == StStart) begin
            start_cnt_d = start_cnt_q + StartW'(1);
        end

        // Restarts on every RUN/SLEW entry; free-runs in RUN as the dither timebase.
        step_cnt_d = '0;
        if ((state_q == StSlew || state_q == StRun) && state_d == state_q) begin
            step_cnt_d = step_wrap ? '0 : step_cnt_q + StepW'(1);
        end

        trim_d = trim_map(cur_code_q + {{(CODE_W-1){1'b0}}, dith_inc});
    end

`ifdef RING_OSC_TRIM_DITHER_EN
    logic frac_q, frac_d;
    logic phase_q, phase_d;

    always_comb begin
        frac_d = handshake ? code_frac : frac_q;
        // Phase is cleared outside RUN, so leaving RUN restores map(cur_code).
        phase_d = 1'b0;
        if (state_q == StRun && state_d == StRun && frac_q && cur_code_q != MaxCode) begin
            phase_d = step_wrap ? ~phase_q : phase_q;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            frac_q  <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            frac_q  <= frac_d;
            phase_q <= phase_d;
        end
    end

    assign dith_inc = phase_q;
`else
    assign dith_inc = 1'b0;
`endif

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cur_code_q  <= '0;
            target_q    <= '0;
            trim_q      <= '0;
            osc_reset_q <= 1'b1;
            start_cnt_q <= '0;
            step_cnt_q  <= '0;
        end else begin
            cur_code_q  <= cur_code_d;
            target_q    <= target_d;
            trim_q      <= trim_d;
            osc_reset_q <= osc_reset_d;
            start_cnt_q <= start_cnt_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    assign trim_out  = trim_q;
    assign osc_reset = osc_reset_q;
    assign cur_code  = cur_code_q;

endmodule
